uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter between two byte-stream requesters: the command-echo path (requester 0) and the score/status reporter (requester 1). It accepts bytes over valid/ready handshakes and issues one `tx_start` pulse per byte. It then tracks the transmitter's `tx_busy` to sequence the next byte. Multi-byte frames are locked to one requester until the requester marks the last byte, so frames never interleave on the line.

---
 rtl/uart_tx_arbiter_if.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester handshakes plus UART transmitter control for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [1:0] grant;
    logic       tx_err;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  tx_busy,
        output req0_ready, req1_ready,
        output tx_start, tx_data, grant, tx_err
    );

    // Requester / transmitter side
    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output tx_busy,
        input  req0_ready, req1_ready,
        input  tx_start, tx_data, grant, tx_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, frame-locked sharing of one UART transmitter by two
//            byte-stream requesters, with a tx_busy rise timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 16
) (
    input  wire logic          clk25MHz,
    input  wire logic          rst_n,
    uart_tx_arbiter_if.slave   bus
);

    localparam int c_CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prio;
    logic               w_prio_nxt;
    logic [1:0]         r_grant;
    logic [1:0]         w_grant_nxt;
    logic               r_tx_start;
    logic               w_tx_start_nxt;
    logic               r_tx_err;
    logic               w_tx_err_nxt;
    logic [7:0]         r_tx_data;
    logic               r_last_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_load;
    logic               w_req0_ready;
    logic               w_req1_ready;
    logic               w_owner_valid;
    logic [7:0]         w_sel_data;
    logic               w_sel_last;

    assign w_owner_valid = r_grant[1] ? bus.req1_valid : bus.req0_valid;
    assign w_sel_data    = r_grant[1] ? bus.req1_data  : bus.req0_data;
    assign w_sel_last    = r_grant[1] ? bus.req1_last  : bus.req0_last;

    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_prio     <= 1'b0;
            r_grant    <= 2'b00;
            r_tx_start <= 1'b0;
            r_tx_err   <= 1'b0;
            r_tx_data  <= 8'h00;
            r_last_q   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_grant    <= w_grant_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_err   <= w_tx_err_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_load) begin
                r_tx_data <= w_sel_data;
                r_last_q  <= w_sel_last;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_prio_nxt     = r_prio;
        w_grant_nxt    = r_grant;
        w_tx_start_nxt = 1'b0;
        w_tx_err_nxt   = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_load         = 1'b0;
        w_req0_ready   = 1'b0;
        w_req1_ready   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    w_state_nxt = S_ISSUE;
                    if (bus.req0_valid && bus.req1_valid)
                        w_grant_nxt = r_prio ? 2'b10 : 2'b01;
                    else
                        w_grant_nxt = bus.req1_valid ? 2'b10 : 2'b01;
                end
            end
            S_ISSUE: begin
                if (w_owner_valid) begin
                    w_req0_ready   = r_grant[0];
                    w_req1_ready   = r_grant[1];
                    w_load         = 1'b1;
                    w_tx_start_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_WAIT_BUSY;
                end else begin
                    // Owner walked away mid-frame: hand the line to the other side.
                    w_grant_nxt = 2'b00;
                    w_prio_nxt  = r_grant[0];
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    // Counter stops at BUSY_TIMEOUT; the byte is treated as sent.
                    w_cnt_nxt    = r_cnt + 1'b1;
                    w_tx_err_nxt = 1'b1;
                    w_state_nxt  = S_WAIT_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (r_last_q) begin
                        w_grant_nxt = 2'b00;
                        w_prio_nxt  = r_grant[0];
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            default: begin
                w_grant_nxt = 2'b00;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.tx_start   = r_tx_start;
    assign bus.tx_data    = r_tx_data;
    assign bus.grant      = r_grant;
    assign bus.tx_err     = r_tx_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench with a transmitted-byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int c_BT = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk25MHz = 1'b0;
    logic rst_n    = 1'b1;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.BUSY_TIMEOUT(c_BT)) dut (
        .clk25MHz (clk25MHz),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #20 clk25MHz = ~clk25MHz;

    beat_t      q0[$];
    beat_t      q1[$];
    logic [7:0] exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         sb_pops     = 0;
    bit         tie_low     = 1'b0;
    int         busy_len    = 10;
    bit         prev_start  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk25MHz);
    endtask

    task automatic wait_tx_start(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            smp();
            if (bus.tx_start) break;
        end
        chk(tag, 32'(bus.tx_start), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 1000; i++) begin
            smp();
            if (bus.grant == 2'b00 && exp_q.size() == 0 && q0.size() == 0 &&
                q1.size() == 0 && !bus.tx_busy) break;
        end
        chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Requester 0 model: presents its queue head, pops on handshake
    initial begin
        bit hs;
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req0_last  = 1'b0;
        forever begin
            @(negedge clk25MHz);
            hs = bus.req0_valid && bus.req0_ready;
            @(posedge clk25MHz);
            #1;
            if (hs && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                bus.req0_valid = 1'b1;
                bus.req0_data  = q0[0].data;
                bus.req0_last  = q0[0].last;
            end else begin
                bus.req0_valid = 1'b0;
            end
        end
    end

    initial begin
        bit hs;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;
        bus.req1_last  = 1'b0;
        forever begin
            @(negedge clk25MHz);
            hs = bus.req1_valid && bus.req1_ready;
            @(posedge clk25MHz);
            #1;
            if (hs && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                bus.req1_valid = 1'b1;
                bus.req1_data  = q1[0].data;
                bus.req1_last  = q1[0].last;
            end else begin
                bus.req1_valid = 1'b0;
            end
        end
    end

    // Transmitter model: busy rises one cycle after tx_start, lasts busy_len cycles
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk25MHz);
            if (bus.tx_start && !tie_low) begin
                @(posedge clk25MHz);
                #1 bus.tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk25MHz);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk25MHz);
            if (bus.tx_start) begin
                chk("start_gap", 32'(prev_start), 32'd0);
                chk("sb_expected_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("sb_tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                    sb_pops++;
                end
            end
            prev_start = bus.tx_start;
        end
    end

    initial begin
        int base;
        int errs;
        int starts;

        #5 rst_n = 1'b0;
        repeat (2) smp();
        chk("rst_grant",    32'(bus.grant),      32'd0);
        chk("rst_tx_start", 32'(bus.tx_start),   32'd0);
        chk("rst_tx_data",  32'(bus.tx_data),    32'd0);
        chk("rst_tx_err",   32'(bus.tx_err),     32'd0);
        chk("rst_ready0",   32'(bus.req0_ready), 32'd0);
        chk("rst_ready1",   32'(bus.req1_ready), 32'd0);
        @(posedge clk25MHz);
        #1 rst_n = 1'b1;
        smp();

        // Single byte with exact cycle positions
        busy_len = 10;
        q0.push_back('{8'h61, 1'b1});
        exp_q.push_back(8'h61);
        smp();
        chk("t1_c0_grant",  32'(bus.grant),      32'd0);
        chk("t1_c0_ready0", 32'(bus.req0_ready), 32'd0);
        smp();
        chk("t1_c1_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t1_c1_grant",  32'(bus.grant),      32'd1);
        chk("t1_c1_start",  32'(bus.tx_start),   32'd0);
        smp();
        chk("t1_c2_start",  32'(bus.tx_start),   32'd1);
        chk("t1_c2_data",   32'(bus.tx_data),    32'h61);
        repeat (11) smp();
        chk("t1_c13_grant", 32'(bus.grant),      32'd1);
        smp();
        chk("t1_c14_grant", 32'(bus.grant),      32'd0);
        wait_idle("t1");

        // prio now points at req1: req1 must win a tie
        busy_len = 4;
        q0.push_back('{8'h71, 1'b1});
        q1.push_back('{8'h53, 1'b1});
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h71);
        wait_idle("prio1");

        // Abandon: req1 sends a non-last byte then drops valid
        q1.push_back('{8'h5A, 1'b0});
        exp_q.push_back(8'h5A);
        wait_idle("abandon");

        // Contention after abandon: prio = 0, so req0 first, then alternate
        q0.push_back('{8'h71, 1'b1});
        q1.push_back('{8'h53, 1'b1});
        exp_q.push_back(8'h71);
        exp_q.push_back(8'h53);
        wait_idle("cont1");
        q0.push_back('{8'h41, 1'b1});
        q1.push_back('{8'h42, 1'b1});
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        wait_idle("cont2");

        // Frame lock: req1 three-byte frame, req0 waiting throughout
        base = sb_pops;
        q1.push_back('{8'h53, 1'b0});
        q1.push_back('{8'h31, 1'b0});
        q1.push_back('{8'h0A, 1'b1});
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h30);
        smp();
        smp();
        chk("lock_grant", 32'(bus.grant), 32'd2);
        q0.push_back('{8'h30, 1'b1});
        for (int i = 0; i < 400; i++) begin
            smp();
            if (bus.req0_ready) begin
                chk("lock_ready0_after_frame", 32'(sb_pops - base), 32'd3);
                break;
            end
        end
        wait_idle("lock");

        // Timeout with tx_busy held low
        tie_low = 1'b1;
        q0.push_back('{8'h7E, 1'b1});
        exp_q.push_back(8'h7E);
        wait_tx_start("to_start", 50);
        errs = 0;
        for (int k = 1; k < c_BT; k++) begin
            smp();
            if (bus.tx_err) errs++;
        end
        chk("to_early_err", 32'(errs), 32'd0);
        smp();
        chk("to_err_pulse", 32'(bus.tx_err), 32'd1);
        chk("to_err_grant", 32'(bus.grant),  32'd1);
        smp();
        chk("to_err_clear", 32'(bus.tx_err), 32'd0);
        chk("to_idle_grant", 32'(bus.grant), 32'd0);
        tie_low = 1'b0;
        wait_idle("to");

        // Asynchronous reset while in WAIT_DONE with tx_busy high
        busy_len = 30;
        q0.push_back('{8'h55, 1'b1});
        exp_q.push_back(8'h55);
        wait_tx_start("rs_start", 50);
        repeat (3) smp();
        chk("rs_pre_busy",  32'(bus.tx_busy), 32'd1);
        chk("rs_pre_grant", 32'(bus.grant),   32'd1);
        #7 rst_n = 1'b0;
        #1;
        chk("rs_grant",    32'(bus.grant),      32'd0);
        chk("rs_tx_data",  32'(bus.tx_data),    32'd0);
        chk("rs_tx_start", 32'(bus.tx_start),   32'd0);
        chk("rs_tx_err",   32'(bus.tx_err),     32'd0);
        chk("rs_ready0",   32'(bus.req0_ready), 32'd0);
        chk("rs_ready1",   32'(bus.req1_ready), 32'd0);
        repeat (2) @(posedge clk25MHz);
        #5 rst_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            smp();
            if (bus.tx_start) starts++;
        end
        chk("rs_no_start", 32'(starts), 32'd0);
        q0.push_back('{8'h4E, 1'b1});
        exp_q.push_back(8'h4E);
        wait_idle("rs_resume");

        chk("sb_final_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
